// File: rtl/bp_stats_unit.sv
// Branch/jump prediction statistics: five event counters with sticky overflow,
// a rolling misprediction window with threshold alarm, and a registered readout port.
module bp_stats_unit #(
    parameter int CNT_WIDTH    = 32,
    parameter int WINDOW_LEN   = 64,
    parameter int ALARM_THRESH = 8,
    parameter int SATURATE     = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic                               ev_branch,
    input  logic                               ev_jump,
    input  logic                               ev_taken,
    input  logic                               misprediction,
    input  logic                               clear,
    input  logic                               freeze,
    input  logic [2:0]                         rd_sel,
    output logic [CNT_WIDTH-1:0]               rd_data,
    output logic                               win_valid,
    output logic [$clog2(WINDOW_LEN+1)-1:0]    win_mispred,
    output logic                               alarm
);

    localparam int WM_W  = $clog2(WINDOW_LEN + 1);
    localparam int EC_W  = $clog2(WINDOW_LEN);
    localparam int RD_W0 = (CNT_WIDTH > WM_W) ? CNT_WIDTH : WM_W;
    localparam int RD_W  = (RD_W0 > 6) ? RD_W0 : 6;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [EC_W-1:0]      EC_LAST = EC_W'(WINDOW_LEN - 1);

    logic [CNT_WIDTH-1:0] cnt_q [5];
    logic [CNT_WIDTH-1:0] cnt_d [5];
    logic [4:0]           ovf_q, ovf_d;
    logic [EC_W-1:0]      evCount_q, evCount_d;
    logic [WM_W-1:0]      mpCount_q, mpCount_d;
    logic [WM_W-1:0]      winMispred_q, winMispred_d;
    logic                 winValid_q, winValid_d;
    logic                 alarm_q, alarm_d;
    logic [CNT_WIDTH-1:0] rdData_q, rdData_d;

    logic                 qualEvent;
    logic                 isJump;
    logic                 isBranch;
    logic [4:0]           incEn;
    logic [WM_W-1:0]      mpSum;
    logic [RD_W-1:0]      rdItem;

    // A simultaneous branch+jump is treated purely as a jump; clear and freeze drop events.
    always_comb begin
        qualEvent = load & (ev_branch | ev_jump) & ~freeze & ~clear;
        isJump    = ev_jump;
        isBranch  = ev_branch & ~ev_jump;
        incEn[0]  = qualEvent & isBranch;
        incEn[1]  = qualEvent & isBranch & misprediction;
        incEn[2]  = qualEvent & isJump;
        incEn[3]  = qualEvent & isJump & misprediction;
        incEn[4]  = qualEvent & isBranch & ev_taken;
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        ovf_d = ovf_q;
        if (clear) begin
            for (int i = 0; i < 5; i++) begin
                cnt_d[i] = '0;
            end
            ovf_d = '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (incEn[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // The window closes on its last event, folding that event's misprediction into the result.
    always_comb begin
        mpSum        = mpCount_q + WM_W'(misprediction);
        evCount_d    = evCount_q;
        mpCount_d    = mpCount_q;
        winMispred_d = winMispred_q;
        alarm_d      = alarm_q;
        winValid_d   = 1'b0;
        if (clear) begin
            evCount_d    = '0;
            mpCount_d    = '0;
            winMispred_d = '0;
            alarm_d      = 1'b0;
        end else if (qualEvent) begin
            if (evCount_q == EC_LAST) begin
                winMispred_d = mpSum;
                alarm_d      = int'(mpSum) > ALARM_THRESH;
                evCount_d    = '0;
                mpCount_d    = '0;
                winValid_d   = 1'b1;
            end else begin
                evCount_d = evCount_q + EC_W'(1);
                mpCount_d = mpSum;
            end
        end
    end

    // Readout samples pre-update state, so it keeps working through clear and freeze.
    always_comb begin
        rdItem = '0;
        case (rd_sel)
            3'd0:    rdItem = RD_W'(cnt_q[0]);
            3'd1:    rdItem = RD_W'(cnt_q[1]);
            3'd2:    rdItem = RD_W'(cnt_q[2]);
            3'd3:    rdItem = RD_W'(cnt_q[3]);
            3'd4:    rdItem = RD_W'(cnt_q[4]);
            3'd5:    rdItem = RD_W'(winMispred_q);
            3'd6:    rdItem = RD_W'(evCount_q);
            default: rdItem = RD_W'({alarm_q, ovf_q});
        endcase
        rdData_d = rdItem[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q        <= '0;
            evCount_q    <= '0;
            mpCount_q    <= '0;
            winMispred_q <= '0;
            winValid_q   <= 1'b0;
            alarm_q      <= 1'b0;
            rdData_q     <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q        <= ovf_d;
            evCount_q    <= evCount_d;
            mpCount_q    <= mpCount_d;
            winMispred_q <= winMispred_d;
            winValid_q   <= winValid_d;
            alarm_q      <= alarm_d;
            rdData_q     <= rdData_d;
        end
    end

    assign rd_data     = rdData_q;
    assign win_valid   = winValid_q;
    assign win_mispred = winMispred_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_bp_stats_unit.sv
// Randomised scoreboard bench for bp_stats_unit: one saturating and one wrapping
// instance share stimulus and are compared against a behavioural statistics model.
module tb_bp_stats_unit;

    localparam int CW    = 6;
    localparam int WL    = 4;
    localparam int TH    = 2;
    localparam int MAXV  = (1 << CW) - 1;
    localparam int WMW   = $clog2(WL + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic load, evBranch, evJump, evTaken, mispred, clr, frz;
    logic [2:0] rdSel;

    logic [CW-1:0]  rdDataSat, rdDataWrap;
    logic           winValidSat, winValidWrap;
    logic [WMW-1:0] winMisSat, winMisWrap;
    logic           alarmSat, alarmWrap;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 is the saturating instance, 1 the wrapping instance.
    int cntM [2][5];
    int ovfM [2];
    int ecM, mcM, winMisM;
    bit alarmM;

    typedef struct {
        int rdA;
        int rdB;
        int winMis;
        bit alarm;
        bit winValid;
    } exp_t;
    exp_t expQ[$];

    bp_stats_unit #(.CNT_WIDTH(CW), .WINDOW_LEN(WL), .ALARM_THRESH(TH), .SATURATE(1)) dutSat (
        .clk(clk), .rst_n(rst_n), .load(load), .ev_branch(evBranch), .ev_jump(evJump),
        .ev_taken(evTaken), .misprediction(mispred), .clear(clr), .freeze(frz),
        .rd_sel(rdSel), .rd_data(rdDataSat), .win_valid(winValidSat),
        .win_mispred(winMisSat), .alarm(alarmSat)
    );

    bp_stats_unit #(.CNT_WIDTH(CW), .WINDOW_LEN(WL), .ALARM_THRESH(TH), .SATURATE(0)) dutWrap (
        .clk(clk), .rst_n(rst_n), .load(load), .ev_branch(evBranch), .ev_jump(evJump),
        .ev_taken(evTaken), .misprediction(mispred), .clear(clr), .freeze(frz),
        .rd_sel(rdSel), .rd_data(rdDataWrap), .win_valid(winValidWrap),
        .win_mispred(winMisWrap), .alarm(alarmWrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) cntM[k][i] = 0;
            ovfM[k] = 0;
        end
        ecM = 0;
        mcM = 0;
        winMisM = 0;
        alarmM = 0;
    endtask

    task automatic bump(input int k, input int i);
        if (cntM[k][i] + 1 > MAXV) begin
            ovfM[k] |= (1 << i);
            cntM[k][i] = (k == 0) ? MAXV : (cntM[k][i] + 1) % (MAXV + 1);
        end else begin
            cntM[k][i] = cntM[k][i] + 1;
        end
    endtask

    function automatic int itemOf(input int k, input int sel);
        case (sel)
            0, 1, 2, 3, 4: return cntM[k][sel];
            5:             return winMisM;
            6:             return ecM;
            default:       return (int'(alarmM) << 5) | ovfM[k];
        endcase
    endfunction

    task automatic applyStimulus(input bit ld, input bit br, input bit jp, input bit tk,
                                 input bit mp, input bit cl, input bit fz, input int sel);
        exp_t e;
        bit   wv;
        @(negedge clk);
        load = ld; evBranch = br; evJump = jp; evTaken = tk;
        mispred = mp; clr = cl; frz = fz; rdSel = 3'(sel);
        e.rdA = itemOf(0, sel);
        e.rdB = itemOf(1, sel);
        wv = 0;
        if (cl) begin
            modelReset();
        end else if (ld && (br || jp) && !fz) begin
            for (int k = 0; k < 2; k++) begin
                if (jp) begin
                    bump(k, 2);
                    if (mp) bump(k, 3);
                end else begin
                    bump(k, 0);
                    if (mp) bump(k, 1);
                    if (tk) bump(k, 4);
                end
            end
            if (ecM == WL - 1) begin
                winMisM = mcM + int'(mp);
                alarmM  = winMisM > TH;
                ecM = 0;
                mcM = 0;
                wv  = 1;
            end else begin
                ecM = ecM + 1;
                mcM = mcM + int'(mp);
            end
        end
        e.winMis   = winMisM;
        e.alarm    = alarmM;
        e.winValid = wv;
        expQ.push_back(e);
    endtask

    task automatic readAll();
        for (int s = 0; s < 8; s++) applyStimulus(0, 0, 0, 0, 0, 0, 0, s);
    endtask

    task automatic idleInputs();
        load = 0; evBranch = 0; evJump = 0; evTaken = 0;
        mispred = 0; clr = 0; frz = 0; rdSel = 3'd0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rdSat"},    int'(rdDataSat),    0);
        checkOutput({tag, "_rdWrap"},   int'(rdDataWrap),   0);
        checkOutput({tag, "_winValid"}, int'(winValidSat),  0);
        checkOutput({tag, "_winMis"},   int'(winMisSat),    0);
        checkOutput({tag, "_alarm"},    int'(alarmSat),     0);
        checkOutput({tag, "_alarmW"},   int'(alarmWrap),    0);
    endtask

    // Monitor: every clock after a stimulus step, the DUT outputs must match the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rdDataSat",    int'(rdDataSat),    e.rdA);
                checkOutput("rdDataWrap",   int'(rdDataWrap),   e.rdB);
                checkOutput("winValidSat",  int'(winValidSat),  int'(e.winValid));
                checkOutput("winValidWrap", int'(winValidWrap), int'(e.winValid));
                checkOutput("winMisSat",    int'(winMisSat),    e.winMis);
                checkOutput("winMisWrap",   int'(winMisWrap),   e.winMis);
                checkOutput("alarmSat",     int'(alarmSat),     int'(e.alarm));
                checkOutput("alarmWrap",    int'(alarmWrap),    int'(e.alarm));
            end
        end
    end

    initial begin
        idleInputs();
        modelReset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 10 branches (3 mispredicted, 6 taken) then 4 jumps (1 mispredicted)
        for (int i = 0; i < 14; i++)
            applyStimulus(1, i < 10, i >= 10, i < 6, (i < 3) || (i == 10), 0, 0, 6);
        readAll();

        // Clear beats a simultaneous mispredicted branch
        applyStimulus(1, 1, 0, 1, 1, 1, 0, 1);
        readAll();

        // Window with 3 mispredictions, then a clean window
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, i < 3, 0, 0, 5);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0, 5);
        // Exactly-threshold window must not alarm
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, i < 2, 0, 0, 7);

        // Frozen events are ignored
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 1, 1, 0, 1, i);
        readAll();

        // Branch+jump+taken counts as a jump only
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 2);
        readAll();

        // Saturate / wrap every counter and set all overflow flags
        for (int i = 0; i < MAXV + 4; i++) applyStimulus(1, 1, 0, 1, 1, 0, 0, i % 8);
        for (int i = 0; i < MAXV + 4; i++) applyStimulus(1, 0, 1, 0, 1, 0, 0, i % 8);
        readAll();

        // Reset mid-window at ec=2 after a window that left win_mispred=3 and alarm set
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, i < 3, 0, 0, 5);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 5);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 5);
        @(negedge clk);
        idleInputs();
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midReset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 1, 0, 0, 6);
        readAll();

        // Randomised traffic
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                          int'($urandom_range(0, 7)));
        readAll();

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
